// File: rtl/ps2_rx_fifo_pkg.sv
// ps2_rx_fifo_pkg
// Shared definitions for the PS/2 receiver. This package holds the following:
//   - the receive FSM state type
//   - the number of data bits in a frame
//   - the break prefix byte
//   - the width of one FIFO entry
//   - the odd-parity check helper
// When KBD_BREAK_TAG_EN is defined, each FIFO entry gets an extra break tag bit
// above the scancode byte.
`timescale 1ns/1ps

package ps2_rx_fifo_pkg;

  // Frame position. The start bit is consumed in IDLE; DATA takes eight bits.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_state_t;

  localparam int DATA_BITS = 8;

  // Scancode that announces that the following code is a key release.
  localparam logic [7:0] BREAK_PREFIX = 8'hF0;

`ifdef KBD_BREAK_TAG_EN
  localparam int ENTRY_WIDTH = 9;
`else
  localparam int ENTRY_WIDTH = 8;
`endif

  // PS/2 uses odd parity: the data byte and the parity bit together carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data_byte, input logic parity_bit);
    return ^{data_byte, parity_bit};
  endfunction

endpackage

// File: rtl/ps2_rx_fifo_sync_fifo.sv
// sync_fifo
// This is a single-clock first-word-fall-through FIFO with registered storage.
// The head entry appears on head_data whenever empty is low. When the FIFO is empty,
// head_data is forced to zero.
// Ports:
//   clk, rst_n   system clock and synchronous active-low reset
//   push         write request
//   push_data    data to write
//   pop          read request; it is ignored while the FIFO is empty
//   head_data    entry at the head of the FIFO
//   empty        FIFO holds no entries
//   count        current occupancy, 0..DEPTH
//   push_accept  the push in this cycle is taken. This allows a push on a full FIFO
//                when a pop happens in the same cycle.
`timescale 1ns/1ps

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   push_accept
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             full;
  logic             do_pop;

  // The pointers carry one extra MSB, so the difference between them is the occupancy.
  // This also lets a full FIFO be told apart from an empty one.
  assign count       = wr_ptr - rd_ptr;
  assign empty       = (count == '0);
  assign full        = (count == (AW+1)'(DEPTH));
  assign do_pop      = pop && !empty;
  assign push_accept = push && (!full || do_pop);
  assign head_data   = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_accept) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)      rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // The storage has no reset. An entry is only ever visible after it has been written.
  always_ff @(posedge clk) begin
    if (push_accept) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo
// PS/2 keyboard receiver. Both PS/2 pins are oversampled in the system clock.
// Frames are checked, and each good byte is queued in a valid/ready FIFO for the CPU
// keyboard port.
// Optional feature (macro KBD_BREAK_TAG_EN): a good 0xF0 byte is absorbed rather than
// queued. The next good byte is then tagged with rd_break.
// Ports:
//   clk, rst_n        system clock and synchronous active-low reset
//   ps2_clk, ps2_data raw asynchronous PS/2 pins
//   rd_data           scancode at the FIFO head
//   rd_break          head entry is a key release; this output is 0 without KBD_BREAK_TAG_EN
//   rd_valid          FIFO not empty
//   rd_ready          consumer pops the head when this is high together with rd_valid
//   count             FIFO occupancy
//   overflow          sticky flag: a good byte was dropped because the FIFO was full
//   parity_err        sticky flag: a frame arrived with even parity
//   frame_err         sticky flag: a stop bit was 0, or a frame timed out mid-frame
//   err_clr           clears the three sticky flags; a simultaneous set wins
`timescale 1ns/1ps

import ps2_rx_fifo_pkg::*;

module ps2_rx_fifo #(
  parameter int DEPTH          = 16,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ps2_clk,
  input  logic                   ps2_data,
  output logic [7:0]             rd_data,
  output logic                   rd_break,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   parity_err,
  output logic                   frame_err,
  input  logic                   err_clr
);

  localparam int FW   = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic             clk_meta, clk_sync, data_meta, data_sync;
  logic             clk_filt;
  logic [FW-1:0]    filt_cnt;
  logic             fall_edge;

  ps2_state_t       state, next_state;
  logic [7:0]       shift_reg;
  logic [2:0]       bit_cnt;
  logic             parity_bit;
  logic [TO_W-1:0]  to_cnt;
  logic             timeout_hit;

  logic             frame_good;
  logic             push_req;
  logic             set_parity_err;
  logic             set_frame_err;
  logic             push_accept;
  logic             fifo_empty;

  logic [ENTRY_WIDTH-1:0] push_entry;
  logic [ENTRY_WIDTH-1:0] head_entry;

  // Two-flop synchronisers. They reset to the idle-high level so that a reset does not
  // look like a falling clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk;
      clk_sync  <= clk_meta;
      data_meta <= ps2_data;
      data_sync <= data_meta;
    end
  end

  // Glitch filter. The filtered level follows the synced clock only after FILTER_LEN
  // consecutive samples that differ from it. filt_cnt counts the differing samples seen
  // before the current one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_filt <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_sync == clk_filt) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
      clk_filt <= clk_sync;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  // The edge is flagged in the cycle whose clock edge drops the filtered level. The data
  // pin sampled in that same cycle is the bit being received.
  assign fall_edge = clk_filt && !clk_sync && (filt_cnt == FW'(FILTER_LEN - 1));

  // A stalled frame is abandoned once TIMEOUT_CYCLES cycles pass without an edge.
  // An edge in that same cycle keeps the frame alive.
  assign timeout_hit = (state != ST_IDLE) && !fall_edge && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // FSM next state. Progress happens only on filtered falling edges, with the timeout as
  // the one exception.
  always_comb begin
    next_state = state;
    if (timeout_hit) begin
      next_state = ST_IDLE;
    end else if (fall_edge) begin
      case (state)
        ST_IDLE:   if (!data_sync) next_state = ST_DATA;
        ST_DATA:   if (bit_cnt == 3'(DATA_BITS - 1)) next_state = ST_PARITY;
        ST_PARITY: next_state = ST_STOP;
        ST_STOP:   next_state = ST_IDLE;
        default:   next_state = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: the frame verdict in the stop-bit edge cycle.
  always_comb begin
    frame_good     = 1'b0;
    push_req       = 1'b0;
    set_parity_err = 1'b0;
    set_frame_err  = timeout_hit;
    if (state == ST_STOP && fall_edge) begin
      frame_good     = odd_parity_ok(shift_reg, parity_bit) && data_sync;
      set_parity_err = !odd_parity_ok(shift_reg, parity_bit);
      if (!data_sync) set_frame_err = 1'b1;
`ifdef KBD_BREAK_TAG_EN
      push_req = frame_good && (shift_reg != BREAK_PREFIX);
`else
      push_req = frame_good;
`endif
    end
  end

  // Receive datapath. The timeout counter restarts on every edge and is held at zero
  // while idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_reg  <= '0;
      bit_cnt    <= '0;
      parity_bit <= 1'b0;
      to_cnt     <= '0;
    end else begin
      if (fall_edge || state == ST_IDLE) to_cnt <= '0;
      else                               to_cnt <= to_cnt + 1'b1;

      if (fall_edge) begin
        case (state)
          ST_IDLE:   bit_cnt <= '0;
          ST_DATA: begin
            shift_reg <= {data_sync, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 1'b1;
          end
          ST_PARITY: parity_bit <= data_sync;
          default: ;
        endcase
      end
    end
  end

  // Sticky error flags. A set in the same cycle as err_clr takes priority over the clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (push_req && !push_accept) overflow <= 1'b1;
      else if (err_clr)             overflow <= 1'b0;
      if (set_parity_err)           parity_err <= 1'b1;
      else if (err_clr)             parity_err <= 1'b0;
      if (set_frame_err)            frame_err <= 1'b1;
      else if (err_clr)             frame_err <= 1'b0;
    end
  end

`ifdef KBD_BREAK_TAG_EN
  logic break_pending;

  // Break-pending register. A good 0xF0 byte sets it. The next good byte consumes it.
  // Any bad or abandoned frame also clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      break_pending <= 1'b0;
    end else if (set_parity_err || set_frame_err) begin
      break_pending <= 1'b0;
    end else if (frame_good) begin
      break_pending <= (shift_reg == BREAK_PREFIX);
    end
  end

  assign push_entry = {break_pending, shift_reg};
  assign rd_data    = head_entry[7:0];
  assign rd_break   = head_entry[8];
`else
  assign push_entry = shift_reg;
  assign rd_data    = head_entry;
  assign rd_break   = 1'b0;
`endif

  sync_fifo #(
    .WIDTH (ENTRY_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (push_req),
    .push_data   (push_entry),
    .pop         (rd_ready),
    .head_data   (head_entry),
    .empty       (fifo_empty),
    .count       (count),
    .push_accept (push_accept)
  );

  assign rd_valid = !fifo_empty;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo
// Directed testbench for ps2_rx_fifo. It drives the DUT with DEPTH=4 and FILTER_LEN=4.
// The PS/2 bit period is shortened to 40 system clocks. TIMEOUT_CYCLES is shortened to 2000
// so that the whole run stays small.
// The break-tagging expectations follow the KBD_BREAK_TAG_EN macro.
`timescale 1ns/1ps

module tb_ps2_rx_fifo;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 2000;
  localparam int HALF    = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] rd_data;
  logic       rd_break;
  logic       rd_valid;
  logic       rd_ready;
  logic [2:0] count;
  logic       overflow;
  logic       parity_err;
  logic       frame_err;
  logic       err_clr;

  int checks = 0;
  int errors = 0;

  ps2_rx_fifo #(
    .DEPTH          (DEPTH),
    .FILTER_LEN     (4),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rd_data    (rd_data),
    .rd_break   (rd_break),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .count      (count),
    .overflow   (overflow),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .err_clr    (err_clr)
  );

  // 50 MHz system clock
  always #10 clk = ~clk;

  // Advance n clock edges and land 1 ns after the last one. Outputs are then stable and
  // inputs can be changed safely.
  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic clk_level, input logic data_level);
    ps2_clk  = clk_level;
    ps2_data = data_level;
  endtask

  // One PS/2 bit. The data is set up while the clock is high, and the device then drives
  // the clock low for half a period.
  task automatic sendBit(input logic b);
    applyStimulus(1'b1, b);
    waitCycles(HALF);
    ps2_clk = 1'b0;
    waitCycles(HALF);
    ps2_clk = 1'b1;
  endtask

  // Start bit, eight data bits LSB first, and the parity bit.
  task automatic sendHead(input logic [7:0] b, input logic par);
    sendBit(1'b0);
    for (int i = 0; i < 8; i++) sendBit(b[i]);
    sendBit(par);
  endtask

  function automatic logic goodPar(input logic [7:0] b);
    return ~^b;
  endfunction

  task automatic sendFrame(input logic [7:0] b, input logic par, input logic stop);
    sendHead(b, par);
    sendBit(stop);
    waitCycles(HALF);
  endtask

  task automatic sendGood(input logic [7:0] b);
    sendFrame(b, goodPar(b), 1'b1);
  endtask

  // Drops the clock for the stop bit and returns one cycle before the filtered edge.
  // The edge lands as follows:
  //   - two synchroniser stages
  //   - then three differing filter samples
  //   - the fourth sample commits on the next clock
  task automatic timedStop(input logic stop);
    applyStimulus(1'b1, stop);
    waitCycles(HALF);
    ps2_clk = 1'b0;
    waitCycles(5);
  endtask

  task automatic finishStop();
    waitCycles(HALF - 6);
    ps2_clk = 1'b1;
    waitCycles(HALF);
  endtask

  task automatic popOne();
    rd_ready = 1'b1;
    waitCycles(1);
    rd_ready = 1'b0;
  endtask

  task automatic clearFlags();
    err_clr = 1'b1;
    waitCycles(1);
    err_clr = 1'b0;
  endtask

  // All stimulus, in order
  initial begin
    logic [7:0] glitch_byte;
    glitch_byte = 8'h5A;

    rst_n    = 1'b0;
    rd_ready = 1'b0;
    err_clr  = 1'b0;
    applyStimulus(1'b1, 1'b1);
    waitCycles(5);

    $display("[TB] reset state");
    checkOutput("reset rd_valid",   32'(rd_valid),   32'd0);
    checkOutput("reset rd_data",    32'(rd_data),    32'h00);
    checkOutput("reset count",      32'(count),      32'd0);
    checkOutput("reset overflow",   32'(overflow),   32'd0);
    checkOutput("reset parity_err", 32'(parity_err), 32'd0);
    checkOutput("reset frame_err",  32'(frame_err),  32'd0);
    checkOutput("reset rd_break",   32'(rd_break),   32'd0);
    rst_n = 1'b1;
    waitCycles(10);

    $display("[TB] test 1: good frame 0x1C, first-word latency");
    sendHead(8'h1C, 1'b0);
    timedStop(1'b1);
    checkOutput("t1 valid before edge", 32'(rd_valid), 32'd0);
    waitCycles(1);
    checkOutput("t1 valid after edge", 32'(rd_valid), 32'd1);
    checkOutput("t1 rd_data",          32'(rd_data),  32'h1C);
    checkOutput("t1 count",            32'(count),    32'd1);
    finishStop();
    popOne();
    checkOutput("t1 valid after pop", 32'(rd_valid), 32'd0);
    checkOutput("t1 count after pop", 32'(count),    32'd0);

    $display("[TB] test 2: parity error and err_clr");
    sendFrame(8'h1C, 1'b1, 1'b1);
    checkOutput("t2 nothing pushed", 32'(count),      32'd0);
    checkOutput("t2 parity_err",     32'(parity_err), 32'd1);
    checkOutput("t2 frame_err",      32'(frame_err),  32'd0);
    clearFlags();
    checkOutput("t2 parity cleared", 32'(parity_err), 32'd0);
    sendHead(8'h1C, 1'b1);
    timedStop(1'b1);
    err_clr = 1'b1;
    waitCycles(1);
    err_clr = 1'b0;
    checkOutput("t2 set beats clear", 32'(parity_err), 32'd1);
    finishStop();
    clearFlags();
    sendFrame(8'h1C, 1'b0, 1'b0);
    checkOutput("t2 bad stop frame_err", 32'(frame_err),  32'd1);
    checkOutput("t2 bad stop parity ok", 32'(parity_err), 32'd0);
    checkOutput("t2 bad stop no push",   32'(count),      32'd0);
    clearFlags();

    $display("[TB] test 3: mid-frame timeout");
    sendBit(1'b0);
    sendBit(1'b1);
    sendBit(1'b0);
    sendBit(1'b1);
    waitCycles(TIMEOUT - 100);
    checkOutput("t3 no timeout yet", 32'(frame_err), 32'd0);
    waitCycles(200);
    checkOutput("t3 timeout frame_err", 32'(frame_err), 32'd1);
    checkOutput("t3 partial discarded", 32'(count),     32'd0);
    sendGood(8'h29);
    checkOutput("t3 next frame count", 32'(count),   32'd1);
    checkOutput("t3 next frame data",  32'(rd_data), 32'h29);
    popOne();
    clearFlags();

    $display("[TB] test 4: fill, overflow, push+pop at full");
    sendGood(8'h01);
    sendGood(8'h02);
    sendGood(8'h03);
    sendGood(8'h04);
    checkOutput("t4 full count",     32'(count),    32'd4);
    checkOutput("t4 full no ovf",    32'(overflow), 32'd0);
    sendGood(8'h05);
    checkOutput("t4 overflow set",   32'(overflow), 32'd1);
    checkOutput("t4 count kept",     32'(count),    32'd4);
    checkOutput("t4 head intact",    32'(rd_data),  32'h01);
    clearFlags();
    checkOutput("t4 overflow clear", 32'(overflow), 32'd0);
    sendHead(8'h06, goodPar(8'h06));
    timedStop(1'b1);
    rd_ready = 1'b1;
    waitCycles(1);
    rd_ready = 1'b0;
    checkOutput("t4 push+pop count",  32'(count),    32'd4);
    checkOutput("t4 push+pop no ovf", 32'(overflow), 32'd0);
    checkOutput("t4 push+pop head",   32'(rd_data),  32'h02);
    finishStop();
    checkOutput("t4 pop 02", 32'(rd_data), 32'h02);
    popOne();
    checkOutput("t4 pop 03", 32'(rd_data), 32'h03);
    popOne();
    checkOutput("t4 pop 04", 32'(rd_data), 32'h04);
    popOne();
    checkOutput("t4 pop 06", 32'(rd_data), 32'h06);
    popOne();
    checkOutput("t4 drained valid", 32'(rd_valid), 32'd0);
    checkOutput("t4 drained count", 32'(count),    32'd0);

    $display("[TB] test 5: glitch rejection");
    applyStimulus(1'b0, 1'b0);
    waitCycles(2);
    applyStimulus(1'b1, 1'b0);
    waitCycles(20);
    ps2_data = 1'b1;
    waitCycles(20);
    sendGood(8'h5A);
    checkOutput("t5 idle glitch count", 32'(count),   32'd1);
    checkOutput("t5 idle glitch data",  32'(rd_data), 32'h5A);
    popOne();
    sendBit(1'b0);
    for (int i = 0; i < 3; i++) sendBit(glitch_byte[i]);
    applyStimulus(1'b1, 1'b1);
    waitCycles(5);
    ps2_clk = 1'b0;
    waitCycles(2);
    ps2_clk = 1'b1;
    waitCycles(10);
    for (int i = 3; i < 8; i++) sendBit(glitch_byte[i]);
    sendBit(goodPar(glitch_byte));
    sendBit(1'b1);
    waitCycles(HALF);
    checkOutput("t5 data glitch count", 32'(count),      32'd1);
    checkOutput("t5 data glitch data",  32'(rd_data),    32'h5A);
    checkOutput("t5 no parity_err",     32'(parity_err), 32'd0);
    checkOutput("t5 no frame_err",      32'(frame_err),  32'd0);
    popOne();

    $display("[TB] test 6: break prefix handling");
    sendGood(8'hF0);
    sendGood(8'h1C);
`ifdef KBD_BREAK_TAG_EN
    checkOutput("t6 tagged count", 32'(count),    32'd1);
    checkOutput("t6 tagged data",  32'(rd_data),  32'h1C);
    checkOutput("t6 tagged break", 32'(rd_break), 32'd1);
`else
    checkOutput("t6 raw count",        32'(count),    32'd2);
    checkOutput("t6 raw first data",   32'(rd_data),  32'hF0);
    checkOutput("t6 raw first break",  32'(rd_break), 32'd0);
    popOne();
    checkOutput("t6 raw second data",  32'(rd_data),  32'h1C);
    checkOutput("t6 raw second break", 32'(rd_break), 32'd0);
`endif

    $display("[TB] test 7: reset mid-frame");
    sendBit(1'b0);
    sendBit(1'b1);
    sendBit(1'b0);
    rst_n = 1'b0;
    waitCycles(3);
    checkOutput("t7 rst rd_valid",   32'(rd_valid),   32'd0);
    checkOutput("t7 rst rd_data",    32'(rd_data),    32'h00);
    checkOutput("t7 rst rd_break",   32'(rd_break),   32'd0);
    checkOutput("t7 rst count",      32'(count),      32'd0);
    checkOutput("t7 rst overflow",   32'(overflow),   32'd0);
    checkOutput("t7 rst parity_err", 32'(parity_err), 32'd0);
    checkOutput("t7 rst frame_err",  32'(frame_err),  32'd0);
    rst_n = 1'b1;
    waitCycles(10);
    sendGood(8'h3A);
    checkOutput("t7 after rst count",     32'(count),     32'd1);
    checkOutput("t7 after rst data",      32'(rd_data),   32'h3A);
    checkOutput("t7 after rst frame_err", 32'(frame_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
